// File: rtl/usb_token_rx_ctrl.sv
// USB token receiver: collects the 16-bit token body (addr, endp, CRC-5) and reports good/bad.
// Optional address filter is enabled by defining USB_TOKEN_ADDR_FILTER_EN.
module usb_token_rx_ctrl #(
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       packet_start,
  input  logic       shift_enable,
  input  logic       rx_bit,
  input  logic       eop,
  input  logic [6:0] dev_addr,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic       token_valid,
  output logic       crc_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_EOP = 2'd2,
    REPORT   = 2'd3
  } state_t;

  localparam logic [4:0] CRC_SEED     = 5'b11111;
  localparam logic [4:0] CRC_RESIDUAL = 5'b01100;
  localparam logic [4:0] LAST_BIT     = 5'd15;
  localparam logic [9:0] TMO_LIMIT    = 10'(IDLE_TIMEOUT);

  // Serial CRC-5 step, polynomial x^5 + x^2 + 1.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic din);
    logic inv;
    inv = din ^ crc[4];
    return {crc[3], crc[2], crc[1] ^ inv, crc[0], inv};
  endfunction

  state_t      state_r;
  state_t      state_nx_s;
  logic [4:0]  crc_r;
  logic [4:0]  bit_cnt_r;
  logic [9:0]  tmo_cnt_r;
  logic [15:0] cap_r;
  logic        accept_s;
  logic        good_s;
  logic        err_s;
  logic        tmo_expire_s;
  logic        addr_match_s;
  logic        field_unused_s;

`ifdef USB_TOKEN_ADDR_FILTER_EN
  assign addr_match_s   = (cap_r[6:0] == dev_addr);
  assign field_unused_s = ^cap_r[15:11];
`else
  assign addr_match_s   = 1'b1;
  assign field_unused_s = ^{dev_addr, cap_r[15:11]};
`endif

  assign tmo_expire_s = ((tmo_cnt_r + 10'd1) == TMO_LIMIT);

  // Next-state decode; packet_start overrides everything, eop beats a coincident bit.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    good_s     = 1'b0;
    err_s      = 1'b0;
    if (packet_start) begin
      state_nx_s = SHIFT;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = IDLE;
        end
        SHIFT: begin
          if (eop) begin
            state_nx_s = REPORT;
            err_s      = 1'b1;
          end else if (shift_enable) begin
            accept_s = 1'b1;
            if (bit_cnt_r == LAST_BIT) begin
              state_nx_s = WAIT_EOP;
            end else begin
              state_nx_s = SHIFT;
            end
          end else if (tmo_expire_s) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = SHIFT;
          end
        end
        WAIT_EOP: begin
          if (eop) begin
            if (crc_r != CRC_RESIDUAL) begin
              state_nx_s = REPORT;
              err_s      = 1'b1;
            end else if (addr_match_s) begin
              state_nx_s = REPORT;
              good_s     = 1'b1;
            end else begin
              state_nx_s = IDLE;
            end
          end else if (shift_enable) begin
            state_nx_s = REPORT;
            err_s      = 1'b1;
          end else if (tmo_expire_s) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = WAIT_EOP;
          end
        end
        REPORT: begin
          state_nx_s = IDLE;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // CRC, bit/idle counters and the LSB-first capture shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_r     <= CRC_SEED;
      bit_cnt_r <= 5'd0;
      tmo_cnt_r <= 10'd0;
      cap_r     <= 16'd0;
    end else if (packet_start) begin
      crc_r     <= CRC_SEED;
      bit_cnt_r <= 5'd0;
      tmo_cnt_r <= 10'd0;
      cap_r     <= 16'd0;
    end else if (accept_s) begin
      crc_r     <= crc5_next(crc_r, rx_bit);
      bit_cnt_r <= bit_cnt_r + 5'd1;
      tmo_cnt_r <= 10'd0;
      cap_r     <= {rx_bit, cap_r[15:1]};
    end else if ((state_r == SHIFT) || (state_r == WAIT_EOP)) begin
      tmo_cnt_r <= tmo_cnt_r + 10'd1;
    end else begin
      tmo_cnt_r <= 10'd0;
    end
  end

  // Registered outputs: pulses are high during REPORT; addr/endp load only on a good token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      token_valid <= 1'b0;
      crc_error   <= 1'b0;
      addr        <= 7'd0;
      endp        <= 4'd0;
      busy        <= 1'b0;
    end else begin
      token_valid <= good_s;
      crc_error   <= err_s;
      busy        <= (state_nx_s != IDLE);
      if (good_s) begin
        addr <= cap_r[6:0];
        endp <= cap_r[10:7];
      end
    end
  end

endmodule
